adder_pipe: RTL and testbench



---
 rtl/adder_pipe.sv | 156 +++++++++++++++
 tb/tb_adder_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit with valid/ready flow control.
// The WIDTH-bit carry chain is cut into STAGES equal slices. Each stage adds
// one slice and hands its carry and the still-unconsumed operand bits to the
// next stage through flops. The whole pipe advances together, and bubbles are
// not collapsed.
// Optional feature: define ADDER_PIPE_SAT_EN for unsigned saturation on s_o.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int L    = WIDTH / STAGES;
    // Stage k keeps (k+1)*L sum bits; all stages are packed back to back.
    localparam int SUMW = L * STAGES * (STAGES + 1) / 2;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
    end

    logic [STAGES-1:0] v_q;
    logic              en;
    logic [WIDTH-1:0]  bx;
    logic              c0;
    logic [SUMW-1:0]   sum_q, sum_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  sum_last;

    // A full last stage that cannot drain freezes everything, input included.
    assign en          = !v_q[STAGES-1] || out_ready_i;
    assign in_ready_o  = en;
    assign out_valid_o = v_q[STAGES-1];

    // Subtraction is A + ~B + ~borrow.
    assign bx = sub_i ? ~b_i : b_i;
    assign c0 = sub_i ^ cin_i;

    // Valid bits shift with the data; in_ready equals en, so in_valid alone marks acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (en) begin
            v_q <= (v_q << 1) | STAGES'(in_valid_i);
        end
    end

    // Sum, carry and overflow registers of every stage advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            sum_q <= sum_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
        end
    end

    if (STAGES == 1) begin : g_one
        logic [WIDTH:0] add;
        assign add      = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, c0};
        assign sum_d    = add[WIDTH-1:0];
        assign cy_d[0]  = add[WIDTH];
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        assign ovf_d    = a_i[WIDTH-1] ^ bx[WIDTH-1] ^ add[WIDTH-1] ^ add[WIDTH];
    end else begin : g_multi
        // Stage k forwards the upper WIDTH-(k+1)*L bits of A and B' as {b, a}.
        localparam int OPW = L * STAGES * (STAGES - 1);
        logic [OPW-1:0] ops_q, ops_d;

        // Operand slices still waiting for their stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ops_q <= '0;
            end else if (en) begin
                ops_q <= ops_d;
            end
        end

        for (genvar k = 0; k < STAGES; k++) begin : g_stg
            logic [L-1:0] sa, sb;
            logic         ci;
            logic [L:0]   add;

            assign add     = {1'b0, sa} + {1'b0, sb} + {{L{1'b0}}, ci};
            assign cy_d[k] = add[L];

            if (k == 0) begin : g_in
                assign sa            = a_i[L-1:0];
                assign sb            = bx[L-1:0];
                assign ci            = c0;
                assign sum_d[L-1:0]  = add[L-1:0];
            end else begin : g_chain
                localparam int SO  = L * k * (k + 1) / 2;
                localparam int SOP = L * (k - 1) * k / 2;
                localparam int RP  = WIDTH - k * L;
                localparam int OOP = L * (k - 1) * (2 * STAGES - k);
                assign sa                      = ops_q[OOP +: L];
                assign sb                      = ops_q[OOP + RP +: L];
                assign ci                      = cy_q[k-1];
                assign sum_d[SO +: (k + 1) * L] = {add[L-1:0], sum_q[SOP +: k * L]};
            end

            if (k < STAGES - 1) begin : g_fwd
                localparam int R  = WIDTH - (k + 1) * L;
                localparam int OO = L * k * (2 * STAGES - k - 1);
                if (k == 0) begin : g_src_in
                    assign ops_d[OO +: 2 * R] = {bx[L +: R], a_i[L +: R]};
                end else begin : g_src_reg
                    localparam int RP  = WIDTH - k * L;
                    localparam int OOP = L * (k - 1) * (2 * STAGES - k);
                    assign ops_d[OO +: 2 * R] = {ops_q[OOP + RP + L +: R], ops_q[OOP + L +: R]};
                end
            end else begin : g_last
                assign ovf_d = sa[L-1] ^ sb[L-1] ^ add[L-1] ^ add[L];
            end
        end
    end

    assign sum_last = sum_q[SUMW-1 -: WIDTH];
    assign cout_o   = cy_q[STAGES-1];
    assign ovf_o    = ovf_q;

`ifdef ADDER_PIPE_SAT_EN
    logic [STAGES-1:0] sb_q;

    // The op mode travels with the beat so the output mux knows add vs sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else if (en) begin
            sb_q <= (sb_q << 1) | STAGES'(sub_i);
        end
    end

    // Clamp on add carry-out (to all-ones) or sub borrow (to zero).
    assign s_o = (sb_q[STAGES-1] ^ cy_q[STAGES-1]) ? {WIDTH{~sb_q[STAGES-1]}} : sum_last;
`else
    assign s_o = sum_last;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed 8-bit vectors, back-pressure, reset mid-flight,
// and random 32-bit sweeps (STAGES 1/4/32) against an arithmetic reference.
module tb_adder_pipe;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;

    // 8-bit, 2-stage instance
    logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0] a8, b8, s8;

    adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv8), .in_ready_o(ir8),
        .a_i(a8), .b_i(b8), .cin_i(cin8), .sub_i(sub8),
        .out_valid_o(ov8), .out_ready_i(or8), .s_o(s8), .cout_o(co8), .ovf_o(of8)
    );

    // 32-bit instances: index 0 -> STAGES 1, 1 -> 4, 2 -> 32
    logic        iv32[3], ir32[3], ov32[3], or32[3], cin32[3], sub32[3], co32[3], of32[3];
    logic [31:0] a32[3], b32[3], s32[3];

    adder_pipe #(.WIDTH(32), .STAGES(1)) u_dut32_1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv32[0]), .in_ready_o(ir32[0]),
        .a_i(a32[0]), .b_i(b32[0]), .cin_i(cin32[0]), .sub_i(sub32[0]),
        .out_valid_o(ov32[0]), .out_ready_i(or32[0]), .s_o(s32[0]), .cout_o(co32[0]), .ovf_o(of32[0])
    );
    adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut32_4 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv32[1]), .in_ready_o(ir32[1]),
        .a_i(a32[1]), .b_i(b32[1]), .cin_i(cin32[1]), .sub_i(sub32[1]),
        .out_valid_o(ov32[1]), .out_ready_i(or32[1]), .s_o(s32[1]), .cout_o(co32[1]), .ovf_o(of32[1])
    );
    adder_pipe #(.WIDTH(32), .STAGES(32)) u_dut32_32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv32[2]), .in_ready_o(ir32[2]),
        .a_i(a32[2]), .b_i(b32[2]), .cin_i(cin32[2]), .sub_i(sub32[2]),
        .out_valid_o(ov32[2]), .out_ready_i(or32[2]), .s_o(s32[2]), .cout_o(co32[2]), .ovf_o(of32[2])
    );

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        res_t e;
        int   c;
    } pend_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic cin, input logic sub);
        res_t   res;
        longint m, half, ua, ub, sa, sb, r, sr, c;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        c    = longint'(cin);
        if (sub) begin
            r        = ua - ub - c;
            sr       = sa - sb - c;
            res.cout = (r >= 0);
        end else begin
            r        = ua + ub + c;
            sr       = sa + sb + c;
            res.cout = (r > m);
        end
        res.s   = 32'(r & m);
        res.ovf = (sr > half - 1) || (sr < -half);
        if (SAT && !sub && res.cout) res.s = 32'(m);
        if (SAT && sub && !res.cout) res.s = 32'd0;
        return res;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One isolated beat through the 8-bit pipe: accept, 2-cycle latency, value check.
    task automatic beat8(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
        #1 chk({nm, " in_ready"}, 32'(ir8), 32'd1);
        @(posedge clk);
        #1 iv8 = 1'b0;
        @(negedge clk);
        chk({nm, " valid@1"}, 32'(ov8), 32'd0);
        @(negedge clk);
        chk({nm, " valid@2"}, 32'(ov8), 32'd1);
        chk({nm, " s"}, 32'(s8), 32'(es));
        chk({nm, " cout"}, 32'(co8), 32'(ec));
        chk({nm, " ovf"}, 32'(of8), 32'(eo));
    endtask

    // Random stream into one 32-bit instance; lat=1 forces out_ready high and checks latency.
    task automatic sweep(input int j, input int stg, input int nb, input bit lat);
        pend_t q[$];
        pend_t p;
        int    sent = 0;
        int    got  = 0;
        int    cyc  = 0;
        string tag;
        tag = $sformatf("S%0d%s", stg, lat ? "lat" : "rnd");
        while (got < nb && cyc < nb * 8 + 100) begin
            @(negedge clk);
            cyc++;
            or32[j] = lat ? 1'b1 : 1'($urandom_range(0, 1));
            if (sent < nb) begin
                iv32[j]  = 1'b1;
                a32[j]   = $urandom;
                b32[j]   = $urandom;
                cin32[j] = 1'($urandom);
                sub32[j] = 1'($urandom);
            end else begin
                iv32[j] = 1'b0;
            end
            #1;
            chk({tag, " in_ready"}, 32'(ir32[j]), 32'(!(ov32[j] && !or32[j])));
            if (ov32[j] && or32[j]) begin
                if (q.size() == 0) begin
                    chk({tag, " unexpected out"}, 32'(ov32[j]), 32'd0);
                end else begin
                    p = q.pop_front();
                    chk({tag, " s"}, s32[j], p.e.s);
                    chk({tag, " cout"}, 32'(co32[j]), 32'(p.e.cout));
                    chk({tag, " ovf"}, 32'(of32[j]), 32'(p.e.ovf));
                    if (lat) chk({tag, " latency"}, 32'(cyc - p.c), 32'(stg));
                end
                got++;
            end
            if (iv32[j] && ir32[j]) begin
                p.e = ref_model(32, a32[j], b32[j], cin32[j], sub32[j]);
                p.c = cyc;
                q.push_back(p);
                sent++;
            end
        end
        iv32[j] = 1'b0;
        or32[j] = 1'b1;
        if (got < nb) chk({tag, " timeout beats"}, 32'(got), 32'(nb));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[8];
        int    nxt, got, cyc;
        bit    prev_stall;
        logic [7:0] held;
        bit    pat[4];

        vt[0] = '{8'd200, 8'd100, 1'b0, 1'b0, SAT ? 8'hFF : 8'h2C, 1'b1, 1'b0};
        vt[1] = '{8'd5,   8'd7,   1'b0, 1'b1, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b0};
        vt[2] = '{8'd10,  8'd3,   1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
        vt[3] = '{8'h7F,  8'h01,  1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[4] = '{8'h0F,  8'h01,  1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vt[5] = '{8'hFF,  8'hFF,  1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[6] = '{8'h00,  8'h00,  1'b1, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b0, 1'b0};
        vt[7] = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            iv32[j] = 1'b0; or32[j] = 1'b1; a32[j] = '0; b32[j] = '0;
            cin32[j] = 1'b0; sub32[j] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset s", 32'(s8), 32'd0);
        chk("reset cout", 32'(co8), 32'd0);
        chk("reset ovf", 32'(of8), 32'd0);
        for (int j = 0; j < 3; j++) chk($sformatf("reset out_valid32[%0d]", j), 32'(ov32[j]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(ir8), 32'd1);

        // Directed vectors
        for (int i = 0; i < 8; i++)
            beat8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
                  vt[i].s, vt[i].cout, vt[i].ovf);

        // Back-pressure: six beats i+i with out_ready pattern 1,0,0,1
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        nxt = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            or8 = pat[cyc % 4];
            cyc++;
            if (nxt < 6) begin
                iv8 = 1'b1; a8 = 8'(nxt); b8 = 8'(nxt); cin8 = 1'b0; sub8 = 1'b0;
            end else begin
                iv8 = 1'b0;
            end
            #1;
            chk("bp in_ready", 32'(ir8), 32'(!(ov8 && !or8)));
            if (ov8 && !or8) begin
                if (prev_stall) chk("bp stall hold", 32'(s8), 32'(held));
                held = s8;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (ov8 && or8) begin
                chk($sformatf("bp beat%0d", got), 32'(s8), 32'(2 * got));
                got++;
            end
            if (iv8 && ir8) nxt++;
        end
        if (got < 6) chk("bp timeout beats", 32'(got), 32'd6);
        iv8 = 1'b0; or8 = 1'b1;

        // Reset mid-flight: two beats in the pipe, downstream stalled
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b0;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd6;
        @(posedge clk);
        #1 iv8 = 1'b0;
        chk("rst pre out_valid", 32'(ov8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(ov8), 32'd0);
        chk("rst s", 32'(s8), 32'd0);
        chk("rst cout", 32'(co8), 32'd0);
        chk("rst ovf", 32'(of8), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst no emit", 32'(ov8), 32'd0);
        end
        beat8("after rst", 8'd1, 8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);

        // 32-bit sweeps: latency/throughput with out_ready high, then random back-pressure
        sweep(0, 1, 40, 1'b1);
        sweep(1, 4, 40, 1'b1);
        sweep(2, 32, 60, 1'b1);
        sweep(0, 1, 1000, 1'b0);
        sweep(1, 4, 1000, 1'b0);
        sweep(2, 32, 1000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
